// File: rtl/spi_master_t.sv
// ---------------------------------------------------------------------------
// spi_master_t
// Byte-serial SPI transmit master. Pops one byte at a time from a
// first-word-not-fall-through FIFO and sends it MSB first. sclk idles low.
// No chip select is used: the far end frames each byte by counting 8 sclk
// rising edges. A guaranteed low gap follows every byte.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for en=1 with a non-empty FIFO
// RD     | FIFO pop strobe high for this single cycle
// LOAD   | FIFO data valid, captured into the shift register
// LOW    | sclk low phase, CLK_DIV cycles, data already stable
// HIGH   | sclk high phase, CLK_DIV cycles, far end samples on entry
// GAP    | sclk and sdout held low for GAP_CYC cycles after the 8th bit
//
// Parameters:
//   CLK_DIV  clk cycles per sclk phase (4..65535)
//   GAP_CYC  clk cycles of low gap after each byte (4..65535)
//
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_en          transmit enable, only looked at in IDLE
//   i_fifo_empty  source FIFO empty flag
//   i_fifo_q      source FIFO read data, valid the cycle after the pop
//   o_fifo_r_en   FIFO pop strobe, one cycle per byte
//   o_sclk        SPI clock, idle low
//   o_sdout       SPI serial data, MSB first
//   o_busy        high from RD through the last GAP cycle
// ---------------------------------------------------------------------------
module spi_master_t #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP_CYC = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_fifo_empty,
    input  logic [7:0] i_fifo_q,
    output logic       o_fifo_r_en,
    output logic       o_sclk,
    output logic       o_sdout,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LOAD = 3'd2,
        S_LOW  = 3'd3,
        S_HIGH = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_shift_reg;
    logic [2:0]  r_bit_cnt;
    logic [15:0] r_div_cnt;
    logic [15:0] r_gap_cnt;

    logic        r_fifo_r_en;
    logic        r_sclk;
    logic        r_busy;

    logic        w_div_done;
    logic        w_gap_done;
    logic        w_last_bit;

    assign w_div_done = (r_div_cnt == DIV_LAST);
    assign w_gap_done = (r_gap_cnt == GAP_LAST);
    assign w_last_bit = (r_bit_cnt == 3'd7);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_en && !i_fifo_empty) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_LOW;
            end
            S_LOW: begin
                if (w_div_done) begin
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_div_done) begin
                    w_state_nxt = w_last_bit ? S_GAP : S_LOW;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath.
    // Outputs are decoded from the next state so that each one is a flop
    // that already reflects the state being entered (sclk rises on entry
    // to HIGH, falls on entry to LOW or GAP).
    // The shift register MSB is the sdout flop itself: LOAD puts fifo_q[7]
    // there, each HIGH->LOW shift exposes the next bit, and the shift
    // register is cleared on HIGH->GAP so sdout is 0 through the gap.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fifo_r_en <= 1'b0;
            r_sclk      <= 1'b0;
            r_busy      <= 1'b0;
            r_shift_reg <= 8'd0;
            r_bit_cnt   <= 3'd0;
            r_div_cnt   <= 16'd0;
            r_gap_cnt   <= 16'd0;
        end else begin
            r_fifo_r_en <= (w_state_nxt == S_RD);
            r_sclk      <= (w_state_nxt == S_HIGH);
            r_busy      <= (w_state_nxt != S_IDLE);

            case (r_state)
                S_LOAD: begin
                    r_shift_reg <= i_fifo_q;
                    r_bit_cnt   <= 3'd0;
                    r_div_cnt   <= 16'd0;
                end
                S_LOW: begin
                    if (w_div_done) begin
                        r_div_cnt <= 16'd0;
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                S_HIGH: begin
                    if (w_div_done) begin
                        r_div_cnt <= 16'd0;
                        if (w_last_bit) begin
                            r_shift_reg <= 8'd0;
                            r_gap_cnt   <= 16'd0;
                        end else begin
                            r_shift_reg <= {r_shift_reg[6:0], 1'b0};
                            r_bit_cnt   <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (w_gap_done) begin
                        r_gap_cnt <= 16'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_fifo_r_en = r_fifo_r_en;
    assign o_sclk      = r_sclk;
    assign o_sdout     = r_shift_reg[7];
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_spi_master_t.sv
// ---------------------------------------------------------------------------
// tb_spi_master_t
// Directed bench for spi_master_t. Instance A runs at the default timing,
// instance B at CLK_DIV=4 / GAP_CYC=4 for a loopback of random bytes into a
// behavioural SPI receiver (samples sdout on each sclk rising edge).
// ---------------------------------------------------------------------------
module tb_spi_master_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // ---------------- instance A (defaults) ----------------
    logic       en_a;
    logic       empty_a;
    logic [7:0] q_a;
    logic       r_en_a, sclk_a, sdout_a, busy_a;
    logic [7:0] mem_a [0:63];
    int         wr_a = 0;
    int         rd_a = 0;

    assign empty_a = (wr_a == rd_a);
    always @(posedge clk) begin
        if (r_en_a) begin
            q_a  <= mem_a[rd_a];
            rd_a <= rd_a + 1;
        end
    end

    spi_master_t u_dut_a (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en_a),
        .i_fifo_empty (empty_a),
        .i_fifo_q     (q_a),
        .o_fifo_r_en  (r_en_a),
        .o_sclk       (sclk_a),
        .o_sdout      (sdout_a),
        .o_busy       (busy_a)
    );

    // ---------------- instance B (loopback timing) ----------------
    logic       en_b;
    logic       empty_b;
    logic [7:0] q_b;
    logic       r_en_b, sclk_b, sdout_b, busy_b;
    logic [7:0] mem_b [0:63];
    int         wr_b = 0;
    int         rd_b = 0;

    assign empty_b = (wr_b == rd_b);
    always @(posedge clk) begin
        if (r_en_b) begin
            q_b  <= mem_b[rd_b];
            rd_b <= rd_b + 1;
        end
    end

    spi_master_t #(.CLK_DIV(4), .GAP_CYC(4)) u_dut_b (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en_b),
        .i_fifo_empty (empty_b),
        .i_fifo_q     (q_b),
        .o_fifo_r_en  (r_en_b),
        .o_sclk       (sclk_b),
        .o_sdout      (sdout_b),
        .o_busy       (busy_b)
    );

    // ---------------- monitors (sampled on the falling clk edge) ----------
    int         cyc       = 0;
    int         edges_a   = 0;
    int         busy_cnt_a = 0;
    int         hi_run_a  = 0;
    int         hi_bad_a  = 0;
    int         low_run_a = 0;
    int         min_gap_a = 1000;
    int         rx_n_a    = 0;
    logic [7:0] rx_sh_a   = 8'd0;
    logic       prev_a    = 1'b0;
    logic [7:0] rx_a [$];
    int         pop_a [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (busy_a) busy_cnt_a = busy_cnt_a + 1;
        if (r_en_a) pop_a.push_back(cyc);
        if (!rst_n) rx_n_a = 0;
        if (sclk_a && !prev_a) begin
            edges_a = edges_a + 1;
            if (rx_n_a == 0 && rx_a.size() > 0 && low_run_a < min_gap_a)
                min_gap_a = low_run_a;
            rx_sh_a = {rx_sh_a[6:0], sdout_a};
            rx_n_a  = rx_n_a + 1;
            if (rx_n_a == 8) begin
                rx_a.push_back(rx_sh_a);
                rx_n_a = 0;
            end
        end
        if (sclk_a) begin
            hi_run_a  = hi_run_a + 1;
            low_run_a = 0;
        end else begin
            if (hi_run_a != 0 && hi_run_a != 4) hi_bad_a = hi_bad_a + 1;
            hi_run_a  = 0;
            low_run_a = low_run_a + 1;
        end
        prev_a = sclk_a;
    end

    int         edges_b = 0;
    int         rx_n_b  = 0;
    logic [7:0] rx_sh_b = 8'd0;
    logic       prev_b  = 1'b0;
    logic [7:0] rx_b [$];
    int         pop_b [$];

    always @(negedge clk) begin
        if (r_en_b) pop_b.push_back(cyc);
        if (!rst_n) rx_n_b = 0;
        if (sclk_b && !prev_b) begin
            edges_b = edges_b + 1;
            rx_sh_b = {rx_sh_b[6:0], sdout_b};
            rx_n_b  = rx_n_b + 1;
            if (rx_n_b == 8) begin
                rx_b.push_back(rx_sh_b);
                rx_n_b = 0;
            end
        end
        prev_b = sclk_b;
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait until the selected instance has delivered n bytes and is idle.
    task automatic wait_done(input bit sel_b, input int n, input int budget);
        int  k = 0;
        bit  ok;
        ok = sel_b ? (rx_b.size() >= n && !busy_b) : (rx_a.size() >= n && !busy_a);
        while (!ok && k < budget) begin
            @(negedge clk);
            k++;
            ok = sel_b ? (rx_b.size() >= n && !busy_b) : (rx_a.size() >= n && !busy_a);
        end
        chk("wait_done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_edges_a(input int target, input int budget);
        int k = 0;
        while (edges_a < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_edges_timeout", 32'(edges_a >= target), 32'd1);
    endtask

    logic [7:0] exp_b [0:15];

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b0;
        mem_a[0] = 8'hA5;
        wr_a     = 1;

        // reset held with data waiting
        repeat (3) @(negedge clk);
        #1;
        chk("rst_fifo_r_en", 32'(r_en_a), 32'd0);
        chk("rst_sclk",      32'(sclk_a), 32'd0);
        chk("rst_sdout",     32'(sdout_a), 32'd0);
        chk("rst_busy",      32'(busy_a), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        busy_cnt_a = 0;
        #1;
        chk("rd_before_first_edge", 32'(r_en_a), 32'd0);
        @(posedge clk); #1;
        chk("rd_after_first_idle", 32'(r_en_a), 32'd1);
        chk("busy_in_rd",          32'(busy_a), 32'd1);
        @(posedge clk); #1;
        chk("rd_single_cycle",     32'(r_en_a), 32'd0);

        // single byte 0xA5
        wait_done(1'b0, 1, 200);
        chk("a5_byte",      32'(rx_a[0]), 32'h0000_00A5);
        chk("a5_edges",     32'(edges_a), 32'd8);
        chk("a5_busy_cyc",  32'(busy_cnt_a), 32'd74);
        chk("a5_pops",      32'(pop_a.size()), 32'd1);
        chk("a5_high_len",  32'(hi_bad_a), 32'd0);

        // back-to-back 0x00, 0xFF, 0x3C
        @(negedge clk);
        mem_a[1] = 8'h00;
        mem_a[2] = 8'hFF;
        mem_a[3] = 8'h3C;
        wr_a     = 4;
        wait_done(1'b0, 4, 400);
        chk("b2b_byte0",    32'(rx_a[1]), 32'h0000_0000);
        chk("b2b_byte1",    32'(rx_a[2]), 32'h0000_00FF);
        chk("b2b_byte2",    32'(rx_a[3]), 32'h0000_003C);
        chk("b2b_pops",     32'(pop_a.size()), 32'd4);
        chk("b2b_space_1",  32'(pop_a[2] - pop_a[1]), 32'd75);
        chk("b2b_space_2",  32'(pop_a[3] - pop_a[2]), 32'd75);
        chk("b2b_gap_ge8",  32'(min_gap_a >= 8), 32'd1);
        chk("b2b_edges",    32'(edges_a), 32'd32);
        chk("b2b_high_len", 32'(hi_bad_a), 32'd0);

        // empty FIFO: nothing moves
        repeat (100) @(negedge clk);
        chk("empty_edges", 32'(edges_a), 32'd32);
        chk("empty_pops",  32'(pop_a.size()), 32'd4);
        chk("empty_sclk",  32'(sclk_a), 32'd0);

        // en dropped at the 3rd rising edge of 0x5A
        mem_a[4] = 8'h5A;
        mem_a[5] = 8'h81;
        wr_a     = 6;
        wait_edges_a(35, 200);
        en_a = 1'b0;
        wait_done(1'b0, 5, 200);
        repeat (150) @(negedge clk);
        chk("endrop_byte",  32'(rx_a[4]), 32'h0000_005A);
        chk("endrop_edges", 32'(edges_a), 32'd40);
        chk("endrop_pops",  32'(pop_a.size()), 32'd5);
        chk("endrop_fifo_left", 32'(wr_a - rd_a), 32'd1);
        en_a = 1'b1;
        wait_done(1'b0, 6, 200);
        chk("reenable_byte",  32'(rx_a[5]), 32'h0000_0081);
        chk("reenable_edges", 32'(edges_a), 32'd48);

        // async reset between 4th and 5th edges of 0x96 (4th bit is 1)
        mem_a[6] = 8'h96;
        mem_a[7] = 8'hC3;
        wr_a     = 8;
        wait_edges_a(52, 200);
        #1;
        chk("pre_rst_sclk",  32'(sclk_a), 32'd1);
        chk("pre_rst_sdout", 32'(sdout_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_sclk",  32'(sclk_a), 32'd0);
        chk("midrst_sdout", 32'(sdout_a), 32'd0);
        chk("midrst_busy",  32'(busy_a), 32'd0);
        repeat (5) @(negedge clk);
        chk("midrst_no_edges", 32'(edges_a), 32'd52);
        rst_n = 1'b1;
        wait_done(1'b0, 7, 200);
        chk("postrst_byte",  32'(rx_a[6]), 32'h0000_00C3);
        chk("postrst_edges", 32'(edges_a), 32'd60);
        chk("postrst_pops",  32'(pop_a.size()), 32'd8);

        // loopback of 16 random bytes at CLK_DIV=4, GAP_CYC=4
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            mem_b[i] = 8'($urandom_range(0, 255));
            exp_b[i] = mem_b[i];
        end
        wr_b = 16;
        en_b = 1'b1;
        wait_done(1'b1, 16, 1400);
        chk("loop_count", 32'(rx_b.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < rx_b.size())
                chk($sformatf("loop_byte%0d", i), 32'(rx_b[i]), 32'(exp_b[i]));
        end
        chk("loop_edges", 32'(edges_b), 32'd128);
        chk("loop_space", 32'(pop_b[1] - pop_b[0]), 32'd71);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master_t.md
Name: spi_master_t

Overview:
- SPI transmit master, the send-side counterpart of the team's 8-bit SPI slave receiver.
- Pops bytes from a first-word-not-fall-through synchronous FIFO.
- Serialises each byte MSB-first on sdout, with a generated sclk that idles low.
- Data is stable during sclk low and is sampled by the far end on the sclk rising edge.
- No chip select. Byte framing comes from exactly 8 rising edges per byte, followed by a mandatory low gap.

Parameters:
- CLK_DIV, 4: clk cycles per sclk phase. Each low phase and each high phase lasts CLK_DIV cycles. Legal range 4..65535; 4 is the receiver's minimum (2-flop edge sync plus a 3-state bit loop).
- GAP_CYC, 8: clk cycles sclk is held low after the 8th high phase, before the next byte may start. Legal range 4..65535.

Ports:
- clk  input  1  system clock, all logic on its rising edge
- rst  input  1  reset, asynchronous, active-low
- en  input  1  transmit enable, sampled only in IDLE
- fifo_empty  input  1  source FIFO empty flag
- fifo_q  input  8  source FIFO read data, valid the cycle after fifo_r_en
- fifo_r_en  output  1  FIFO pop strobe, one cycle per byte
- sclk  output  1  SPI clock, idle low
- sdout  output  1  SPI serial data, MSB first
- busy  output  1  high from RD through the end of GAP

Behaviour:

Reset:
- Clock and reset are decided: one clock, clk; reset rst is asynchronous and active-low.
- While rst=0, all outputs are 0 immediately: fifo_r_en, sclk, sdout, busy.
- While rst=0, the state is IDLE, the shift register is 0 and all counters are 0.
- Reset mid-byte abandons the byte. sclk drops low asynchronously and no further rising edges occur. The popped byte is lost.

Registers:
- All outputs are registered; there are no combinational paths from inputs to outputs.
- shift_reg[7:0], bit_cnt[2:0], div_cnt[15:0] and gap_cnt[15:0] are internal.

State machine (one-hot or binary, implementer's choice):
- IDLE: sclk=0, busy=0. If en=1 and fifo_empty=0, go to RD. Otherwise stay.
- RD: fifo_r_en=1 for exactly this cycle, busy=1. Always go to LOAD.
- LOAD:
  - fifo_r_en=0. At the end of the cycle, shift_reg<=fifo_q, sdout<=fifo_q[7], bit_cnt<=0, div_cnt<=0.
  - Go to LOW.
- LOW: sclk=0. div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1, clear div_cnt and go to HIGH.
- HIGH:
  - sclk=1. div_cnt counts 0..CLK_DIV-1.
  - At CLK_DIV-1 with bit_cnt=7: go to GAP and load gap_cnt with 0.
  - At CLK_DIV-1 otherwise: shift_reg<={shift_reg[6:0],0}, sdout<=shift_reg[6], bit_cnt<=bit_cnt+1, go to LOW.
- GAP: sclk=0, sdout=0. gap_cnt counts 0..GAP_CYC-1. At GAP_CYC-1, go to IDLE.

Timing:
- sdout changes only on the clk edge that ends a HIGH phase, or in LOAD. It is therefore stable for the whole low phase and the whole high phase.
- sclk is registered: it rises on entry to HIGH and falls on entry to LOW or GAP. There are no glitches.
- Byte time, IDLE decision to next IDLE decision: 3 + 16*CLK_DIV + GAP_CYC cycles (75 at defaults).
- Exactly 8 sclk rising edges per byte.

Boundary conditions:
- The FIFO is never popped when empty; fifo_empty is checked only in IDLE.
- fifo_empty rising during RD or LOAD is ignored; the pop has already been committed.
- en=0 mid-byte has no effect. The current byte and its gap complete, then the block stays in IDLE.
- A back-to-back FIFO leaves exactly one IDLE cycle between GAP and RD.
- fifo_q is sampled only in LOAD; changes to it at other times are ignored.

Test Plan:
- Reset values: hold rst=0 with the FIFO holding data, then release. Required: all outputs 0 during reset; first fifo_r_en one cycle after the first IDLE cycle.
- Single byte 0xA5 at defaults: one fifo_r_en pulse and 8 sclk rising edges, each high for 4 cycles. sdout sampled at the rising edges must read 1,0,1,0,0,1,0,1. busy is high for 2+64+8=74 cycles.
- Back-to-back 0x00, 0xFF, 0x3C: consecutive fifo_r_en pulses exactly 75 cycles apart. Sampled bytes match in order. sclk stays low for ≥8 cycles between bytes.
- Loopback with the SPI slave receiver, driven from the same clk, for 16 random bytes at CLK_DIV=4 and GAP_CYC=4: the receiver FIFO writes the identical 16 bytes in order.
- Empty and enable gating:
  - fifo_empty=1: no fifo_r_en and sclk stays 0.
  - en dropped at the 3rd rising edge of a byte: that byte completes with 8 edges, and no further pop occurs while en=0.
- Async reset mid-byte: assert rst=0 between the 4th and 5th rising edges. Required: sclk=0 and sdout=0 in the same cycle, no further edges. After release, the next byte transmits cleanly from its MSB.
